// File: rtl/fft_stream_ctrl_if.sv
// ----------------------------------------------------------------------------
// fft_stream_ctrl_if
//   Bundles the sample-path signals between the audio FIFO read port, the
//   streaming FFT sink and the fft_stream_ctrl controller.
//
//   FIFO side : fifo_rd_empty (to ctrl), fifo_rdreq (from ctrl),
//               fifo_rd_data (to ctrl, valid the cycle after fifo_rdreq)
//   FFT side  : fft_ready (to ctrl), fft_valid / fft_data / fft_sop /
//               fft_eop / fft_rst_n (from ctrl)
//   Status    : frame_cnt, pad_active (from ctrl)
//
//   Modport master is the controller view, slave is the environment view.
// ----------------------------------------------------------------------------
interface fft_stream_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              fifo_rd_empty;
  logic              fifo_rdreq;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fft_ready;
  logic              fft_valid;
  logic [DATA_W-1:0] fft_data;
  logic              fft_sop;
  logic              fft_eop;
  logic              fft_rst_n;
  logic [15:0]       frame_cnt;
  logic              pad_active;

  modport master (
    input  fifo_rd_empty, fifo_rd_data, fft_ready,
    output fifo_rdreq, fft_valid, fft_data, fft_sop, fft_eop,
           fft_rst_n, frame_cnt, pad_active
  );

  modport slave (
    output fifo_rd_empty, fifo_rd_data, fft_ready,
    input  fifo_rdreq, fft_valid, fft_data, fft_sop, fft_eop,
           fft_rst_n, frame_cnt, pad_active
  );
endinterface

// File: rtl/fft_stream_ctrl.sv
// ----------------------------------------------------------------------------
// fft_stream_ctrl
//   Moves audio samples from the FIFO read port into a streaming FFT sink.
//   After reset the FFT core is held in reset for RST_CYCLES cycles, then the
//   controller waits for fft_ready and streams samples with valid/ready
//   back-pressure, marking the first/last sample of every FFT_LEN-sample
//   frame with fft_sop/fft_eop. Data passes through a registered output
//   stage backed by a one-entry skid buffer, so one sample per cycle is
//   sustained. Completed frames are counted in frame_cnt.
//
//   Ports:
//     sys_clk  - single clock
//     sys_rst  - asynchronous active-low reset
//     bus      - fft_stream_ctrl_if.master (FIFO read port, FFT sink, status)
//
//   Optional feature (macro FFT_STREAM_ZPAD_EN): when a started frame is
//   starved for PAD_TIMEOUT cycles, the rest of the frame is filled with
//   zero samples and pad_active is raised while that happens. Without the
//   macro pad_active is tied low and a starved frame simply waits.
// ----------------------------------------------------------------------------
module fft_stream_ctrl #(
  parameter int DATA_W      = 16,
  parameter int FFT_LEN     = 128,
  parameter int CNT_W       = 8,
  parameter int RST_CYCLES  = 32,
  parameter int PAD_TIMEOUT = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  fft_stream_ctrl_if.master bus
);

  localparam int               RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_WAIT_RDY = 2'd1,
    S_RUN      = 2'd2,
    S_PAD      = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;
  logic              fft_rst_n_q, fft_rst_n_d;
  logic              inflight_q, inflight_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              xfer_s;
  logic              out_free_s;
  logic [1:0]        occ_s;
  logic              room_s;
  logic              rdreq_s;
  logic [CNT_W-1:0]  idx_nx_s;

`ifdef FFT_STREAM_ZPAD_EN
  localparam int             PCW      = $clog2(PAD_TIMEOUT + 1);
  localparam logic [PCW-1:0] PAD_LAST = PCW'(PAD_TIMEOUT - 1);

  logic [PCW-1:0]    starve_q, starve_d;
  logic              pad_active_q, pad_active_d;
  logic              starve_s;
  logic              pad_load_s;
`endif

  // Handshake qualifiers, FIFO read request and index of the next loaded word
  always_comb begin
    xfer_s     = out_vld_q & bus.fft_ready;
    out_free_s = ~out_vld_q | xfer_s;
    // Words held after this edge (output + skid + returning). A new read is
    // only safe if its word still fits when the sink stalls next cycle.
    occ_s      = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, inflight_q};
    room_s     = ((occ_s - {1'b0, xfer_s}) < 2'd2);
    rdreq_s    = (state_q == S_RUN) & ~bus.fifo_rd_empty & room_s;
    if (xfer_s) begin
      if (idx_q == IDX_LAST) begin
        idx_nx_s = {CNT_W{1'b0}};
      end else begin
        idx_nx_s = idx_q + CNT_W'(1);
      end
    end else begin
      idx_nx_s = idx_q;
    end
  end

  // Next-state logic: FSM, reset delay, output stage, skid buffer, counters
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    fft_rst_n_d = fft_rst_n_q;
    inflight_d  = rdreq_s;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    idx_d       = idx_nx_s;
    frame_cnt_d = frame_cnt_q;
`ifdef FFT_STREAM_ZPAD_EN
    starve_d     = starve_q;
    starve_s     = (idx_q != {CNT_W{1'b0}}) & ~out_vld_q & ~skid_vld_q &
                   ~inflight_q & bus.fifo_rd_empty;
    // Keep filling zeros until the frame's last sample sits in the output.
    pad_load_s   = (state_q == S_PAD) & ~(out_vld_q & out_eop_q);
    pad_active_d = pad_active_q;
`endif

    if (xfer_s) begin
      out_vld_d = 1'b0;
      if (out_eop_q) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        frame_cnt_d = frame_cnt_q;
      end
    end else begin
      out_vld_d = out_vld_q;
    end

    // The skid word is older than the returning word, so it goes out first.
    if (out_free_s) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_data_d  = skid_data_q;
        out_sop_d   = (idx_nx_s == {CNT_W{1'b0}});
        out_eop_d   = (idx_nx_s == IDX_LAST);
        skid_vld_d  = inflight_q;
        skid_data_d = bus.fifo_rd_data;
      end else if (inflight_q) begin
        out_vld_d   = 1'b1;
        out_data_d  = bus.fifo_rd_data;
        out_sop_d   = (idx_nx_s == {CNT_W{1'b0}});
        out_eop_d   = (idx_nx_s == IDX_LAST);
        skid_vld_d  = 1'b0;
`ifdef FFT_STREAM_ZPAD_EN
      end else if (pad_load_s) begin
        out_vld_d   = 1'b1;
        out_data_d  = {DATA_W{1'b0}};
        out_sop_d   = (idx_nx_s == {CNT_W{1'b0}});
        out_eop_d   = (idx_nx_s == IDX_LAST);
        skid_vld_d  = 1'b0;
`endif
      end else begin
        skid_vld_d  = 1'b0;
      end
    end else begin
      if (inflight_q) begin
        skid_vld_d  = 1'b1;
        skid_data_d = bus.fifo_rd_data;
      end else begin
        skid_vld_d  = skid_vld_q;
      end
    end

    case (state_q)
      S_HOLD: begin
        if (rst_cnt_q == RST_LAST) begin
          fft_rst_n_d = 1'b1;
          state_d     = S_WAIT_RDY;
        end else begin
          rst_cnt_d   = rst_cnt_q + RCW'(1);
        end
      end
      S_WAIT_RDY: begin
        if (bus.fft_ready) begin
          state_d = S_RUN;
        end else begin
          state_d = S_WAIT_RDY;
        end
      end
      S_RUN: begin
`ifdef FFT_STREAM_ZPAD_EN
        if (inflight_q) begin
          starve_d = {PCW{1'b0}};
        end else if (starve_s) begin
          if (starve_q == PAD_LAST) begin
            starve_d = {PCW{1'b0}};
            state_d  = S_PAD;
          end else begin
            starve_d = starve_q + PCW'(1);
          end
        end else begin
          starve_d = starve_q;
        end
`else
        state_d = S_RUN;
`endif
      end
      S_PAD: begin
`ifdef FFT_STREAM_ZPAD_EN
        if (xfer_s & out_eop_q) begin
          state_d  = S_RUN;
          starve_d = {PCW{1'b0}};
        end else begin
          state_d  = S_PAD;
        end
`else
        state_d = S_HOLD;
`endif
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase

`ifdef FFT_STREAM_ZPAD_EN
    pad_active_d = (state_d == S_PAD);
`endif
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q      <= S_HOLD;
      rst_cnt_q    <= {RCW{1'b0}};
      fft_rst_n_q  <= 1'b0;
      inflight_q   <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_data_q  <= {DATA_W{1'b0}};
      idx_q        <= {CNT_W{1'b0}};
      frame_cnt_q  <= 16'd0;
`ifdef FFT_STREAM_ZPAD_EN
      starve_q     <= {PCW{1'b0}};
      pad_active_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      fft_rst_n_q  <= fft_rst_n_d;
      inflight_q   <= inflight_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      skid_vld_q   <= skid_vld_d;
      skid_data_q  <= skid_data_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef FFT_STREAM_ZPAD_EN
      starve_q     <= starve_d;
      pad_active_q <= pad_active_d;
`endif
    end
  end

  assign bus.fifo_rdreq = rdreq_s;
  assign bus.fft_valid  = out_vld_q;
  assign bus.fft_data   = out_data_q;
  assign bus.fft_sop    = out_sop_q;
  assign bus.fft_eop    = out_eop_q;
  assign bus.fft_rst_n  = fft_rst_n_q;
  assign bus.frame_cnt  = frame_cnt_q;
`ifdef FFT_STREAM_ZPAD_EN
  assign bus.pad_active = pad_active_q;
`else
  assign bus.pad_active = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft_stream_ctrl
//   Directed bench for fft_stream_ctrl: reset hold, ramp framing, random
//   back-pressure, FIFO starvation (with/without FFT_STREAM_ZPAD_EN) and
//   reset in the middle of a stalled frame.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_stream_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst;

  fft_stream_ctrl_if #(.DATA_W(16)) bus ();

  fft_stream_ctrl #(
    .DATA_W(16), .FFT_LEN(128), .CNT_W(8), .RST_CYCLES(32), .PAD_TIMEOUT(64)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO model: words pushed by the stimulus, read data registered
  logic [15:0] fifo_mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_rd_empty = (rd_ptr == wr_ptr);

  always @(posedge sys_clk) begin
    if (bus.fifo_rdreq && (rd_ptr != wr_ptr)) begin
      bus.fifo_rd_data <= fifo_mem[rd_ptr[11:0]];
      rd_ptr           <= rd_ptr + 1;
    end
  end

  // Monitor: logs every transfer and protocol violations at the falling edge
  int          cyc = 0;
  logic [15:0] log_data [0:4095];
  logic        log_sop  [0:4095];
  logic        log_eop  [0:4095];
  logic        log_pad  [0:4095];
  int          log_cyc  [0:4095];
  int          out_n = 0;
  int          viol_empty_rd = 0;
  int          viol_stall = 0;
  int          pad_hi = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_word = 18'd0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (bus.fifo_rdreq && bus.fifo_rd_empty) viol_empty_rd <= viol_empty_rd + 1;
    if (bus.pad_active) pad_hi <= pad_hi + 1;
    if (prev_stall && sys_rst &&
        !(bus.fft_valid && ({bus.fft_data, bus.fft_sop, bus.fft_eop} == prev_word)))
      viol_stall <= viol_stall + 1;
    prev_stall <= bus.fft_valid && !bus.fft_ready && sys_rst;
    prev_word  <= {bus.fft_data, bus.fft_sop, bus.fft_eop};
    if (bus.fft_valid && bus.fft_ready) begin
      log_data[out_n[11:0]] <= bus.fft_data;
      log_sop[out_n[11:0]]  <= bus.fft_sop;
      log_eop[out_n[11:0]]  <= bus.fft_eop;
      log_pad[out_n[11:0]]  <= bus.pad_active;
      log_cyc[out_n[11:0]]  <= cyc;
      out_n                 <= out_n + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] val);
    fifo_mem[wr_ptr[11:0]] = val;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_out(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (out_n < target && k < budget) begin
      @(posedge sys_clk);
      k++;
    end
    #1;
    check_eq(tag, 64'(out_n >= target), 64'd1);
  endtask

  // After reset release: fft_rst_n rise, first read, first valid (sample index)
  task automatic startup(input string tag);
    int c_rise, c_rd, c_val;
    c_rise = -1; c_rd = -1; c_val = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge sys_clk);
      #1;
      if (c_rise < 0 && bus.fft_rst_n)  c_rise = k;
      if (c_rd   < 0 && bus.fifo_rdreq) c_rd   = k;
      if (c_val  < 0 && bus.fft_valid)  c_val  = k;
      if (c_val >= 0) break;
    end
    check_eq({tag, "_rst_hold"},    64'(c_rise), 64'd32);
    check_eq({tag, "_first_rdreq"}, 64'(c_rd),   64'd33);
    check_eq({tag, "_first_valid"}, 64'(c_val),  64'd35);
  endtask

  function automatic logic [37:0] out_vec();
    return {bus.fifo_rdreq, bus.fft_valid, bus.fft_data, bus.fft_sop, bus.fft_eop,
            bus.fft_rst_n, bus.frame_cnt, bus.pad_active};
  endfunction

`ifdef FFT_STREAM_ZPAD_EN
  localparam int T5_N = 22;
`else
  localparam int T5_N = 50;
`endif

  initial begin
    int base, err, cnt;
    logic [15:0] exp_first;

    // ---- reset state and hold ----
    sys_rst       = 1'b0;
    bus.fft_ready = 1'b1;
    for (int i = 0; i < 256; i++) push(16'(i));
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("reset_outs", 64'(out_vec()), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    startup("boot");

    // ---- 256-word ramp, back-to-back ----
    base = 0;
    wait_out(256, 1000, "ramp_done");
    err = 0; cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (log_data[i] != 16'(i)) err++;
      cnt += int'(log_sop[i]) + int'(log_eop[i]);
    end
    check_eq("ramp_data_err", 64'(err), 64'd0);
    check_eq("ramp_marks", {log_sop[0], log_sop[128], log_eop[127], log_eop[255]}, 64'hF);
    check_eq("ramp_mark_cnt", 64'(cnt), 64'd4);
    check_eq("ramp_span", 64'(log_cyc[255] - log_cyc[0]), 64'd255);
    check_eq("ramp_frames", 64'(bus.frame_cnt), 64'd2);

    // ---- 1000 words with random back-pressure ----
    base = out_n;
    for (int i = 0; i < 1000; i++) push(16'(i * 37 + 5));
    for (int k = 0; k < 6000; k++) begin
      @(posedge sys_clk);
      #1;
      if (out_n >= base + 1000) break;
      bus.fft_ready = 1'($urandom_range(0, 1));
    end
    bus.fft_ready = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    check_eq("rand_count", 64'(out_n - base), 64'd1000);
    err = 0;
    for (int i = 0; i < 1000; i++) begin
      if (log_data[base + i] != 16'(i * 37 + 5)) err++;
      if (log_sop[base + i] != ((i % 128) == 0)) err++;
      if (log_eop[base + i] != ((i % 128) == 127)) err++;
    end
    check_eq("rand_seq_err", 64'(err), 64'd0);
    check_eq("rand_frames", 64'(bus.frame_cnt), 64'd9);
    check_eq("stall_stable", 64'(viol_stall), 64'd0);

    // complete the frame left at index 104
    base = out_n;
    for (int i = 0; i < 24; i++) push(16'hA000 + 16'(i));
    wait_out(base + 24, 200, "fill_done");
    check_eq("fill_eop", 64'(log_eop[base + 23]), 64'd1);
    check_eq("fill_frames", 64'(bus.frame_cnt), 64'd10);

    // ---- 100 words, 200 idle cycles, 28 words ----
    base = out_n;
    for (int i = 0; i < 100; i++) push(16'hB000 + 16'(i));
    wait_out(base + 100, 400, "starve_first_part");
    check_eq("starve_sop", 64'(log_sop[base]), 64'd1);
    repeat (200) @(posedge sys_clk);
    #1;
`ifdef FFT_STREAM_ZPAD_EN
    check_eq("pad_count", 64'(out_n - base), 64'd128);
    err = 0;
    for (int i = 100; i < 128; i++) begin
      if (log_data[base + i] != 16'd0) err++;
      if (log_pad[base + i] != 1'b1) err++;
      if (log_eop[base + i] != (i == 127)) err++;
    end
    check_eq("pad_zero_err", 64'(err), 64'd0);
    // 64 starvation cycles, one cycle to load the first zero, one to present it
    check_eq("pad_gap", 64'(log_cyc[base + 100] - log_cyc[base + 99]), 64'd66);
    check_eq("pad_frames", 64'(bus.frame_cnt), 64'd11);
    check_eq("pad_released", 64'(bus.pad_active), 64'd0);
    for (int i = 0; i < 28; i++) push(16'hC000 + 16'(i));
    wait_out(base + 156, 200, "pad_tail_done");
    check_eq("pad_new_sop", {log_sop[base + 128], log_data[base + 128]}, {1'b1, 16'hC000});
`else
    check_eq("idle_no_xfer", 64'(out_n - base), 64'd100);
    for (int i = 0; i < 28; i++) push(16'hC000 + 16'(i));
    wait_out(base + 128, 200, "tail_done");
    cnt = 0;
    for (int i = 0; i < 128; i++) cnt += int'(log_sop[base + i]) + int'(log_eop[base + i]);
    check_eq("tail_eop", {log_eop[base + 127], log_data[base + 127]}, {1'b1, 16'hC01B});
    check_eq("tail_mark_cnt", 64'(cnt), 64'd2);
    check_eq("tail_frames", 64'(bus.frame_cnt), 64'd11);
    check_eq("pad_never", 64'(pad_hi), 64'd0);
`endif

    // ---- reset while stalled at index 50 ----
    base = out_n;
    for (int i = 0; i < 60; i++) push(16'hD000 + 16'(i));
    wait_out(base + T5_N, 200, "mid_reach");
    bus.fft_ready = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    check_eq("mid_stalled", {bus.fft_valid, bus.fft_sop, bus.fft_data},
             {1'b1, 1'b0, 16'hD000 + 16'(T5_N)});
    #1;
    sys_rst = 1'b0;
    #1;
    check_eq("mid_reset_outs", 64'(out_vec()), 64'd0);
    check_eq("mid_no_xfer", 64'(out_n - base), 64'(T5_N));
    repeat (3) @(posedge sys_clk);
    exp_first = fifo_mem[rd_ptr[11:0]];
    base = out_n;
    bus.fft_ready = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    startup("rearm");
    wait_out(base + 1, 50, "rearm_xfer");
    check_eq("rearm_sop", {log_sop[base], log_data[base]}, {1'b1, exp_first});
    check_eq("rearm_frames", 64'(bus.frame_cnt), 64'd0);
    check_eq("never_read_empty", 64'(viol_empty_rd), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_stream_ctrl.md
# fft_stream_ctrl

Parametrised second-generation controller between the audio sample FIFO (read side, `sys_clk` domain) and the streaming FFT IP-core sink. It holds the FFT in reset after system reset, then moves samples from the FIFO to the core with proper valid/ready back-pressure, framing every `FFT_LEN` samples with start/end-of-packet. It also carries the sample data through a registered output stage with a one-entry skid buffer, and counts completed frames.

## Interface
- `DATA_W`, 16, sample width
- `FFT_LEN`, 128, samples per frame (2..2^CNT_W)
- `CNT_W`, 8, width of in-frame index counter
- `RST_CYCLES`, 32, cycles `fft_rst_n` is held low after reset (>=1)
- `PAD_TIMEOUT`, 64, starvation cycles before zero-padding (used only with `FFT_STREAM_ZPAD_EN`)

Ports:
- `sys_clk` in 1: single clock
- `sys_rst` in 1: asynchronous active-low reset
- `fifo_rd_empty` in 1: FIFO empty
- `fifo_rdreq` out 1: FIFO read request; data valid the cycle after
- `fifo_rd_data` in DATA_W: FIFO read data
- `fft_ready` in 1: FFT sink ready
- `fft_valid` out 1: sample valid to FFT
- `fft_data` out DATA_W: sample to FFT
- `fft_sop` out 1: first sample of frame
- `fft_eop` out 1: last sample of frame
- `fft_rst_n` out 1: FFT reset, active low
- `frame_cnt` out 16: completed frames, wraps at 65535->0
- `pad_active` out 1: current frame is being zero-padded

## Operation
- States: HOLD -> WAIT_RDY -> RUN (-> PAD -> RUN with macro).
- HOLD: `fft_rst_n`=0, delay counter counts `RST_CYCLES` cycles, then `fft_rst_n`=1 and go to WAIT_RDY.
- WAIT_RDY: stay until `fft_ready`=1, then RUN. No FIFO reads.
- RUN: `fifo_rdreq` = !`fifo_rd_empty` && skid buffer will have space for the returning word (skid empty, or output stage draining this cycle). Never read an empty FIFO.
- Returning FIFO word loads the output stage if it is empty or draining, else the skid buffer. Skid buffer drains into the output stage first; order preserved.
- Transfer = `fft_valid` && `fft_ready`. While `fft_valid`=1 and `fft_ready`=0, `fft_data`/`fft_sop`/`fft_eop` held stable.
- Index `idx` (CNT_W bits) is assigned when a word enters the output stage: `fft_sop` = (idx==0), `fft_eop` = (idx==FFT_LEN-1). `idx` advances on each transfer, wraps FFT_LEN-1 -> 0. `frame_cnt` increments on each transfer with `fft_eop`=1.
- `fft_ready` low in RUN only stalls; it never resets framing or state.
- Frames never abort: FIFO underrun mid-frame simply drops `fft_valid` until data returns, same `idx` continues.
- Reset mid-operation: all state, in-flight, skid and output contents discarded; return to HOLD.

## Timing
- Reset values: `fifo_rdreq`=0, `fft_valid`=0, `fft_data`=0, `fft_sop`=0, `fft_eop`=0, `fft_rst_n`=0, `frame_cnt`=0, `pad_active`=0, `idx`=0.
- `fft_rst_n` rises on the RST_CYCLES-th rising edge after reset release.
- Read latency: `fifo_rdreq` in cycle n -> `fft_valid` in cycle n+2 (unstalled).
- Sustained throughput 1 sample/cycle with `fft_ready`=1 and FIFO non-empty.
- `fifo_rdreq` is combinational from `fifo_rd_empty`, `fft_ready` and registered state; all other outputs registered.
- First `fifo_rdreq` possible in the first RUN cycle.

## Configuration
- `FFT_STREAM_ZPAD_EN` defined: in RUN with idx!=0 and no word in output stage, skid buffer or in flight, a starvation counter increments; at `PAD_TIMEOUT` go to PAD. PAD: `fifo_rdreq`=0, `pad_active`=1, emit `fft_data`=0 samples with normal handshake/index until the eop transfer, then `pad_active`=0, counter cleared, back to RUN. Counter clears on any FIFO word. Padded frames count in `frame_cnt`.
- Not defined: no PAD state, `pad_active` tied 0, starvation waits indefinitely.

## Test plan
- Reset release, `fft_ready`=1 -> `fft_rst_n` low exactly 32 cycles, `fifo_rdreq` stays 0 until RUN.
- FIFO preloaded with 256 ramp words 0..255, `fft_ready`=1 -> 256 back-to-back transfers, `fft_sop` on data 0 and 128, `fft_eop` on 127 and 255, `frame_cnt`=2.
- Random `fft_ready` toggling (50%) over 1000 samples -> output sequence equals input, no loss or duplication, outputs stable while stalled, `fifo_rdreq` never asserted with `fifo_rd_empty`=1.
- 100 words then FIFO empty 200 cycles then 28 words, macro off -> single frame, eop on word 127, `pad_active` never 1.
- Same stimulus, macro on -> 64 starvation cycles after word 99, then 28 zero samples with eop on the last, `pad_active` high for them, `frame_cnt`=1. The subsequent 28 words start a new frame with sop.
- `sys_rst` asserted mid-frame (idx=50) while stalled -> all outputs at reset values immediately; after release a new 32-cycle hold and frame restarts with sop.
